// File: rtl/gin_pkg.sv
// Shared types and default sizing for the GIN multicast channel.
package gin_pkg;

  localparam int DEF_PE_ROW   = 6;
  localparam int DEF_PE_COL   = 8;
  localparam int DEF_XID_BITS = 5;
  localparam int DEF_YID_BITS = 3;
  localparam int DEF_DATA     = 32;
  localparam int PE_NUM       = DEF_PE_ROW * DEF_PE_COL;

  localparam logic [DEF_XID_BITS-1:0] ID_NONE_X = {DEF_XID_BITS{1'b1}};
  localparam logic [DEF_YID_BITS-1:0] ID_NONE_Y = {DEF_YID_BITS{1'b1}};

  typedef enum logic {
    IDLE    = 1'b0,
    DELIVER = 1'b1
  } state_e;

endpackage

// File: rtl/gin_id_scan_chain.sv
// Shift-register chain of PE IDs; the first value shifted in ends up in ids[0].
module gin_id_scan_chain #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] scan_in,
  output logic [WIDTH-1:0] ids [DEPTH]
);

  logic [WIDTH-1:0] r_ids [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_ids[i] <= '1;
    end else if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) r_ids[i] <= r_ids[i+1];
      r_ids[DEPTH-1] <= scan_in;
    end
  end

  assign ids = r_ids;

endmodule

// File: rtl/gin_multicast_channel.sv
// GIN channel: captures one tagged word and multicasts it to every PE whose (YID, XID) matches.
// Define GIN_FULL_THRU_EN to accept a new word in the completion cycle (one word per cycle).
module gin_multicast_channel import gin_pkg::*; #(
  parameter int NUMS_PE_ROW = DEF_PE_ROW,
  parameter int NUMS_PE_COL = DEF_PE_COL,
  parameter int XID_BITS    = DEF_XID_BITS,
  parameter int YID_BITS    = DEF_YID_BITS,
  parameter int DATA_SIZE   = DEF_DATA
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             set_XID,
  input  logic [XID_BITS-1:0]              XID_scan_in,
  input  logic                             set_YID,
  input  logic [YID_BITS-1:0]              YID_scan_in,
  input  logic [XID_BITS-1:0]              tag_X,
  input  logic [YID_BITS-1:0]              tag_Y,
  input  logic                             GLB_valid,
  output logic                             GLB_ready,
  input  logic [DATA_SIZE-1:0]             data_in,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_ready,
  output logic [DATA_SIZE-1:0]             PE_data,
  output logic                             busy,
  output logic                             drop
);

  localparam int PEN = NUMS_PE_ROW * NUMS_PE_COL;
  localparam logic [XID_BITS-1:0] XNONE = {XID_BITS{1'b1}};
  localparam logic [YID_BITS-1:0] YNONE = {YID_BITS{1'b1}};

  logic [XID_BITS-1:0]  w_xid [PEN];
  logic [YID_BITS-1:0]  w_yid [NUMS_PE_ROW];
  logic [PEN-1:0]       w_target, w_peValid, w_accept, r_delivered;
  logic [DATA_SIZE-1:0] r_data;
  logic [XID_BITS-1:0]  r_tagX;
  logic [YID_BITS-1:0]  r_tagY;
  logic                 w_glbReady, w_glbAccept, w_done;
  state_e               r_state, w_nextState;

  gin_id_scan_chain #(.DEPTH(PEN), .WIDTH(XID_BITS)) u_xChain (
    .clk(clk), .rst(rst), .shift_en(set_XID), .scan_in(XID_scan_in), .ids(w_xid)
  );

  gin_id_scan_chain #(.DEPTH(NUMS_PE_ROW), .WIDTH(YID_BITS)) u_yChain (
    .clk(clk), .rst(rst), .shift_en(set_YID), .scan_in(YID_scan_in), .ids(w_yid)
  );

  // Unprogrammed (all-ones) IDs never match, even against an all-ones tag.
  for (genvar i = 0; i < PEN; i++) begin : g_match
    assign w_target[i] = (w_xid[i] == r_tagX) && (w_yid[i / NUMS_PE_COL] == r_tagY) &&
                         (w_xid[i] != XNONE) && (w_yid[i / NUMS_PE_COL] != YNONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_glbReady  = 1'b0;
    w_peValid   = '0;
    w_done      = 1'b0;
    busy        = 1'b0;
    drop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_glbReady = ~set_XID;
        if (GLB_valid && w_glbReady) w_nextState = DELIVER;
      end
      DELIVER: begin
        busy = 1'b1;
        if (!set_XID) begin
          w_peValid = w_target & ~r_delivered;
          w_done    = ((w_target & ~(r_delivered | (w_peValid & PE_ready))) == '0);
          drop      = w_done && (w_target == '0);
        end
`ifdef GIN_FULL_THRU_EN
        w_glbReady = w_done;
`endif
        if (w_done) w_nextState = (GLB_valid && w_glbReady) ? DELIVER : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign GLB_ready   = rst & w_glbReady;
  assign w_glbAccept = GLB_valid & GLB_ready;
  assign w_accept    = w_peValid & PE_ready;
  assign PE_valid    = w_peValid;
  assign PE_data     = r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data      <= '0;
      r_tagX      <= '0;
      r_tagY      <= '0;
      r_delivered <= '0;
    end else begin
      if (w_glbAccept) begin
        r_data <= data_in;
        r_tagX <= tag_X;
        r_tagY <= tag_Y;
      end
      if (r_state == DELIVER) r_delivered <= w_done ? '0 : (r_delivered | w_accept);
    end
  end

endmodule

// File: tb/tb_gin_multicast_channel.sv
// Directed self-checking bench for gin_multicast_channel (default or GIN_FULL_THRU_EN build).
module tb_gin_multicast_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_XID, set_YID;
  logic [4:0]  XID_scan_in, tag_X;
  logic [2:0]  YID_scan_in, tag_Y;
  logic        GLB_valid, GLB_ready;
  logic [31:0] data_in, PE_data;
  logic [47:0] PE_valid, PE_ready;
  logic        busy, drop;

  int errors = 0;
  int checks = 0;

  gin_multicast_channel dut (
    .clk(clk), .rst(rst), .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in), .tag_X(tag_X), .tag_Y(tag_Y),
    .GLB_valid(GLB_valid), .GLB_ready(GLB_ready), .data_in(data_in),
    .PE_valid(PE_valid), .PE_ready(PE_ready), .PE_data(PE_data),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // xmode 0: xid = i%8, 1: all 1, 2: all 3; YIDs 0..5 when doY is set.
  task automatic scanIds(input int xmode, input bit doY);
    for (int i = 0; i < 48; i++) begin
      set_XID     = 1'b1;
      XID_scan_in = (xmode == 0) ? 5'(i % 8) : (xmode == 1) ? 5'd1 : 5'd3;
      set_YID     = doY && (i < 6);
      YID_scan_in = 3'(i);
      tick();
    end
    set_XID = 1'b0;
    set_YID = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] x, input logic [2:0] y, input logic [31:0] d);
    GLB_valid = 1'b1;
    tag_X     = x;
    tag_Y     = y;
    data_in   = d;
    #1;
    checkOutput("accept_ready", 64'(GLB_ready), 64'd1);
    tick();
    GLB_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [47:0] expMask;
    logic [31:0] words [4];
    int wi, cnt, first, last;
    logic adv;

    rst = 1'b0; set_XID = 1'b0; set_YID = 1'b0; XID_scan_in = '0; YID_scan_in = '0;
    tag_X = '0; tag_Y = '0; GLB_valid = 1'b0; data_in = '0; PE_ready = '0;
    tick(); tick();
    checkOutput("rst_glb_ready", 64'(GLB_ready), 64'd0);
    checkOutput("rst_pe_valid", 64'(PE_valid), 64'd0);
    checkOutput("rst_pe_data", 64'(PE_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_drop", 64'(drop), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_ready", 64'(GLB_ready), 64'd1);

    // Unprogrammed IDs are all ones and must never match an all-ones tag.
    applyStimulus(5'd31, 3'd7, 32'h1);
    checkOutput("none_drop", 64'(drop), 64'd1);
    checkOutput("none_valid", 64'(PE_valid), 64'd0);
    tick();

    // Single-target delivery: (X=3,Y=2) -> PE 19.
    scanIds(0, 1'b1);
    PE_ready = '1;
    applyStimulus(5'd3, 3'd2, 32'hA5A5A5A5);
    checkOutput("t1_valid", 64'(PE_valid), 64'(48'h1 << 19));
    checkOutput("t1_data", 64'(PE_data), 64'hA5A5A5A5);
    checkOutput("t1_busy", 64'(busy), 64'd1);
`ifdef GIN_FULL_THRU_EN
    checkOutput("t1_glb_ready", 64'(GLB_ready), 64'd1);
`else
    checkOutput("t1_glb_ready", 64'(GLB_ready), 64'd0);
`endif
    tick();
    checkOutput("t1_valid_after", 64'(PE_valid), 64'd0);
    checkOutput("t1_ready_after", 64'(GLB_ready), 64'd1);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);

    // Row multicast with staggered readies: (X=1,Y=4) -> PEs 32..39.
    scanIds(1, 1'b1);
    PE_ready = '0;
    applyStimulus(5'd1, 3'd4, 32'h12345678);
    expMask = 48'hFF << 32;
    checkOutput("t2_valid_held", 64'(PE_valid), 64'(expMask));
    tick();
    checkOutput("t2_valid_still", 64'(PE_valid), 64'(expMask));
    for (int k = 0; k < 8; k++) begin
      PE_ready[32+k] = 1'b1;
      #1;
      checkOutput("t2_busy", 64'(busy), 64'd1);
      tick();
      expMask[32+k] = 1'b0;
      checkOutput("t2_valid_step", 64'(PE_valid), 64'(expMask));
    end
    checkOutput("t2_idle_busy", 64'(busy), 64'd0);
    checkOutput("t2_idle_ready", 64'(GLB_ready), 64'd1);
    PE_ready = '0;

    // Y=7 is ID_NONE: dropped.
    applyStimulus(5'd7, 3'd7, 32'hDEAD0000);
    checkOutput("t3_drop", 64'(drop), 64'd1);
    checkOutput("t3_valid", 64'(PE_valid), 64'd0);
    tick();
    checkOutput("t3_drop_once", 64'(drop), 64'd0);
    checkOutput("t3_ready", 64'(GLB_ready), 64'd1);

    // Reset with a partially delivered word.
    PE_ready = 48'h1 << 32;
    applyStimulus(5'd1, 3'd4, 32'hCAFEF00D);
    checkOutput("t4_valid0", 64'(PE_valid), 64'(48'hFF << 32));
    tick();
    checkOutput("t4_partial", 64'(PE_valid), 64'(48'hFE << 32));
    rst = 1'b0;
    #1;
    checkOutput("t4_ready_in_rst", 64'(GLB_ready), 64'd0);
    tick();
    checkOutput("t4_valid", 64'(PE_valid), 64'd0);
    checkOutput("t4_data", 64'(PE_data), 64'd0);
    checkOutput("t4_busy", 64'(busy), 64'd0);
    checkOutput("t4_drop", 64'(drop), 64'd0);
    rst = 1'b1;
    PE_ready = '0;
    #1;
    checkOutput("t4_ready_after", 64'(GLB_ready), 64'd1);
    applyStimulus(5'd1, 3'd4, 32'h0);
    checkOutput("t4_ids_cleared", 64'(drop), 64'd1);
    tick();

    // Rescan during DELIVER: stalls, then targets row 2 under the new XIDs.
    scanIds(0, 1'b1);
    applyStimulus(5'd3, 3'd2, 32'h0BADBEEF);
    checkOutput("t5_valid_before", 64'(PE_valid), 64'(48'h1 << 19));
    for (int i = 0; i < 48; i++) begin
      set_XID = 1'b1;
      XID_scan_in = 5'd3;
      #1;
      checkOutput("t5_stall_valid", 64'(PE_valid), 64'd0);
      checkOutput("t5_stall_ready", 64'(GLB_ready), 64'd0);
      tick();
    end
    set_XID = 1'b0;
    #1;
    checkOutput("t5_resume", 64'(PE_valid), 64'(48'hFF << 16));
    checkOutput("t5_data", 64'(PE_data), 64'h0BADBEEF);
    PE_ready = '1;
    tick();
    checkOutput("t5_done", 64'(busy), 64'd0);

    // Streaming throughput into PE 19.
    scanIds(0, 1'b1);
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    wi = 0; cnt = 0; first = -1; last = -1;
    tag_X = 5'd3; tag_Y = 3'd2;
    for (int cyc = 0; cyc < 40 && cnt < 4; cyc++) begin
      GLB_valid = (wi < 4);
      data_in   = words[wi < 4 ? wi : 3];
      #1;
      if (PE_valid[19] && PE_ready[19]) begin
        checkOutput("tp_data", 64'(PE_data), 64'(words[cnt]));
        if (cnt == 0) first = cyc;
        last = cyc;
        cnt++;
      end
      adv = GLB_valid & GLB_ready;
      tick();
      if (adv) wi++;
    end
    GLB_valid = 1'b0;
    checkOutput("tp_count", 64'(cnt), 64'd4);
`ifdef GIN_FULL_THRU_EN
    checkOutput("tp_span", 64'(last - first), 64'd3);
`else
    checkOutput("tp_span", 64'(last - first), 64'd6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gin_multicast_channel.md
Name: gin_multicast_channel

Overview:
- One Global Input Network (GIN) channel: the receiving end of the controller's ifmap, filter or ipsum valid/ready stream.
- Holds the PE-array XID/YID scan chains.
- Captures one tagged word at a time and multicasts it to every PE whose (YID, XID) matches the tag, with a per-PE valid/ready handshake.
- Instantiated once per GIN data type between the pass controller and the PE array.

Parameters:
- NUMS_PE_ROW, 6, PE array rows
- NUMS_PE_COL, 8, PE array columns
- XID_BITS, 5, column-ID width
- YID_BITS, 3, row-ID width
- DATA_SIZE, 32, data word width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- set_XID  in  1  XID scan enable
- XID_scan_in  in  XID_BITS  XID shifted in per set_XID cycle
- set_YID  in  1  YID scan enable
- YID_scan_in  in  YID_BITS  YID shifted in per set_YID cycle
- tag_X  in  XID_BITS  destination X tag, sampled at accept
- tag_Y  in  YID_BITS  destination Y tag, sampled at accept
- GLB_valid  in  1  controller word valid
- GLB_ready  out  1  channel can accept
- data_in  in  DATA_SIZE  word from GLB
- PE_valid  out  NUMS_PE_ROW*NUMS_PE_COL  per-PE valid (index = row*NUMS_PE_COL+col)
- PE_ready  in  NUMS_PE_ROW*NUMS_PE_COL  per-PE ready
- PE_data  out  DATA_SIZE  broadcast data
- busy  out  1  word held, not fully delivered
- drop  out  1  one-cycle pulse: held word matched no PE

Behaviour:
- Reset (rst==0 at posedge):
  - state IDLE; GLB_ready=0 during reset, 1 afterwards.
  - PE_valid=0, PE_data=0, busy=0, drop=0, delivered mask=0.
  - All XID/YID registers = ID_NONE (all ones).
  - Reset mid-delivery discards the held word.
- XID scan: each cycle set_XID=1, xid[i]<=xid[i+1] and xid[N-1]<=XID_scan_in, with N=ROW*COL. After N shifts the first value sent sits in xid[0].
- YID scan: same scheme over NUMS_PE_ROW entries, on set_YID; set_YID is only ever high while set_XID is high.
- PE i has row = i / NUMS_PE_COL.
- Match: PE i is targeted iff xid[i]==hold_X and yid[row]==hold_Y. A PE with either ID equal to ID_NONE is never targeted.
- FSM:
  - IDLE: GLB_ready=1 unless set_XID=1.
    - GLB_valid & GLB_ready -> register data_in/tag_X/tag_Y, go DELIVER.
  - DELIVER: busy=1; GLB_ready=0 (without the optional feature).
    - PE_valid[i] = target[i] & ~delivered[i] & ~set_XID.
    - PE_data = held data.
    - PE_valid[i] & PE_ready[i] -> delivered[i]<=1.
    - Completion when target is a subset of (delivered | this-cycle accepts): next IDLE, delivered<=0.
    - Target empty: drop=1 for one cycle, next IDLE; nothing driven to PEs.
- PE_valid, once high, stays high with data stable until that PE accepts.
- PEs may accept in different cycles; each PE receives the word exactly once.
- set_XID during DELIVER:
  - Delivery stalls: PE_valid masked to 0, delivered mask kept.
  - Target is recomputed from the new IDs after the scan.
- Latency: word visible on PE_valid one cycle after acceptance.
- Throughput: at most one word per two cycles without the optional feature.

Optional Feature:
- GIN_FULL_THRU_EN defined:
  - In DELIVER, GLB_ready=1 in the completion cycle (or the drop cycle).
  - An accept in that cycle loads the next word directly and stays in DELIVER, giving one word per cycle when all targets are ready.
  - This creates a combinational PE_ready->GLB_ready path.
- Undefined: GLB_ready is registered-state only (IDLE & ~set_XID).

Decomposition:
- Package gin_pkg:
  - state enum {IDLE, DELIVER}
  - ID_NONE_X / ID_NONE_Y constants (all ones)
  - PE_NUM = NUMS_PE_ROW*NUMS_PE_COL
- Sub-module gin_id_scan_chain (parameters DEPTH, WIDTH; ports clk, rst, shift_en, scan_in, ids[DEPTH]), instantiated for X (DEPTH=PE_NUM) and Y (DEPTH=NUMS_PE_ROW).

Test Plan:
- Scan XIDs i%8 for i=0..47 and YIDs 0..5, then send tag(X=3,Y=2) data=0xA5A5A5A5 with all PE_ready=1 -> PE_valid only bit 19 for one cycle; PE_data=0xA5A5A5A5; GLB_ready back high the cycle after.
- Scan all XIDs=1, YIDs=0..5, send tag(1,4) with PE_ready=0 -> PE_valid bits 32..39 held. Raise readies one per cycle -> each bit drops after its accept; IDLE after the 8th.
- Send tag(7,7) (Y=7 = ID_NONE) -> drop pulses once, PE_valid stays 0, channel back to IDLE.
- Pull rst low for one cycle while in DELIVER with a partial delivered mask -> all outputs 0, IDs all ones, GLB_ready=1 the cycle after release.
- Raise set_XID for 48 cycles during DELIVER -> PE_valid=0 and GLB_ready=0 throughout; delivery resumes against the new IDs.
- With GIN_FULL_THRU_EN, stream 4 words to a single always-ready PE -> 4 accepts in 4 consecutive cycles; without the macro -> 8 cycles.
